// File: rtl/demux1_8_deser.sv
// Serial-to-parallel 1:8 demultiplexer: LSB-first bits are collected into a byte
// and handed off through a valid/ready output. Optional macro DEMUX_PARITY_CHECK_EN adds a 9th even-parity slot.
module demux1_8_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [2:0] sel,
  output logic       parity_err
);

  // state   | meaning
  // COLLECT | filling data slots; every offered bit is taken
  // LAST    | next accepted bit completes the frame; may stall on a held byte
  typedef enum logic {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } state_t;

`ifdef DEMUX_PARITY_CHECK_EN
  localparam int SEL_W = 4;
  localparam int COL_W = 8;
`else
  localparam int SEL_W = 3;
  localparam int COL_W = 7;
`endif
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(COL_W);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [7:0]        dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              held;
  logic              accept;
  logic              complete;
  logic [7:0]        frame_byte;
  logic [SEL_W-1:0]  sel_inc;

  assign held      = dout_valid_q & ~dout_ready;
  assign din_ready = ~flush & ~((state_q == LAST) & held);
  assign accept    = din_valid & din_ready;
  assign complete  = accept & (state_q == LAST);
  assign sel_inc   = sel_q + SEL_W'(1);

`ifdef DEMUX_PARITY_CHECK_EN
  logic perr_q, perr_d;
  logic frame_par;

  assign frame_byte = col_q;
  assign frame_par  = (^col_q) ^ din;
  assign parity_err = perr_q;
  // The parity slot is shown as 7 so sel stays within its 3-bit range.
  assign sel        = (sel_q == LAST_IDX) ? 3'd7 : sel_q[2:0];

  always_comb begin
    perr_d = perr_q;
    if (complete) perr_d = frame_par;
  end

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
`else
  assign frame_byte = {din, col_q};
  assign parity_err = 1'b0;
  assign sel        = sel_q;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    col_d   = col_q;
    if (flush) begin
      state_d = COLLECT;
      sel_d   = '0;
      col_d   = '0;
    end else if (accept) begin
      if (state_q == LAST) begin
        state_d = COLLECT;
        sel_d   = '0;
        col_d   = '0;
      end else begin
        col_d[sel_q[2:0]] = din;
        sel_d             = sel_inc;
        state_d           = (sel_inc == LAST_IDX) ? LAST : COLLECT;
      end
    end
  end

  // A completing frame takes precedence over consumption so the handoff has no bubble.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (complete) begin
      dout_d       = frame_byte;
      dout_valid_d = 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      sel_q        <= '0;
      col_q        <= '0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      col_q        <= col_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

endmodule

// File: tb/tb_demux1_8_deser.sv
// Self-checking bench for demux1_8_deser: table-driven frames plus hand sequences for
// stall, flush and reset; a scoreboard queue checks every consumed byte.
module tb_demux1_8_deser;

`ifdef DEMUX_PARITY_CHECK_EN
  localparam int FRAME = 9;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FRAME = 8;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, din, din_valid, din_ready;
  logic [7:0] dout;
  logic       dout_valid, dout_ready;
  logic [2:0] sel;
  logic       parity_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_perr;
  } vec_t;
  vec_t vecs[4];

  demux1_8_deser dut (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .sel(sel), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", dout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_dout", dout, e.d);
        chk("sb_perr", parity_err, e.p);
      end
    end
  end

  task automatic idle(input int n);
    din_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int idx);
    int n;
    n = 0;
    chk("sel_before_bit", sel, (idx < 8) ? idx : 7);
    din = b;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got din_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] data, input logic par, input int gap,
                           input bit push, input logic [7:0] exp_d, input logic exp_p);
    exp_t e;
    for (int i = 0; i < FRAME; i++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      send_bit((i < 8) ? data[i] : par, i);
    end
    if (push) begin
      e.d = exp_d;
      e.p = exp_p;
      sb.push_back(e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'h4D, par: 1'b0, gap: 0, exp_dout: 8'h4D, exp_perr: 1'b0};
    vecs[1] = '{data: 8'h4D, par: 1'b1, gap: 0, exp_dout: 8'h4D, exp_perr: PAR_EN};
    vecs[2] = '{data: 8'h81, par: 1'b0, gap: 5, exp_dout: 8'h81, exp_perr: 1'b0};
    vecs[3] = '{data: 8'h3C, par: 1'b1, gap: 2, exp_dout: 8'h3C, exp_perr: PAR_EN};

    rst = 1'b1; flush = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_sel", sel, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_din_ready", din_ready, 1);

    // back-to-back 4D: valid exactly one cycle after the last accept, for one cycle
    send_byte(8'h4D, 1'b0, 0, 1'b1, 8'h4D, 1'b0);
    chk("lat_valid", dout_valid, 1);
    chk("lat_dout", dout, 8'h4D);
    idle(1);
    chk("lat_valid_drop", dout_valid, 0);

    for (int v = 0; v < 4; v++)
      send_byte(vecs[v].data, vecs[v].par, vecs[v].gap, 1'b1, vecs[v].exp_dout, vecs[v].exp_perr);
    idle(2);

    // held byte: final bit of next frame stalls, then completes the same cycle it is consumed
    dout_ready = 1'b0;
    send_byte(8'hA5, 1'b0, 0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < FRAME - 1; i++) send_bit((i < 8) ? 1'(8'h3C >> i) : 1'b0, i);
    chk("stall_sel", sel, 7);
    din = PAR_EN ? 1'b0 : 1'b0;
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", din_ready, 0);
      chk("stall_dout", dout, 8'hA5);
    end
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", din_ready, 1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sb.push_back('{d: 8'h3C, p: 1'b0});
    chk("nobubble_valid", dout_valid, 1);
    chk("nobubble_dout", dout, 8'h3C);
    idle(2);

    // flush mid-frame
    for (int i = 0; i < 3; i++) send_bit(1'b0, i);
    flush = 1'b1; din = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    chk("flush_ready", din_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0; din_valid = 1'b0;
    chk("flush_sel", sel, 0);
    send_byte(8'hFF, 1'b0, 0, 1'b1, 8'hFF, 1'b0);
    idle(2);

    // reset mid-frame with a held byte
    dout_ready = 1'b0;
    send_byte(8'h5A, 1'b0, 0, 1'b0, 8'h00, 1'b0);
    chk("held_valid", dout_valid, 1);
    for (int i = 0; i < 3; i++) send_bit(1'b0, i);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst2_valid", dout_valid, 0);
    chk("rst2_dout", dout, 8'h00);
    chk("rst2_sel", sel, 0);
    chk("rst2_ready", din_ready, 1);
    dout_ready = 1'b1;
    send_byte(8'hFF, 1'b0, 0, 1'b1, 8'hFF, 1'b0);
    idle(3);
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux1_8_deser.md
DEMUX1_8_DESER -- requirements
Module: demux1_8_deser

Interface
REQ-001 Parameters: none; frame data width fixed at 8 bits, demux select width fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  synchronous discard of the partial frame in collection.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  din carries a bit this cycle.
REQ-007 din_ready  output  1  block accepts din this cycle (combinational).
REQ-008 dout  output  8  assembled byte; dout[k] is the bit received with select k.
REQ-009 dout_valid  output  1  dout holds an unconsumed byte.
REQ-010 dout_ready  input  1  consumer takes dout this cycle.
REQ-011 sel  output  3  current demux select (bit index of the next accepted bit).
REQ-012 parity_err  output  1  parity status of the byte in dout (see Configuration).

Function
REQ-013 Accept occurs when din_valid & din_ready; accepted bit is written to collect slot col[sel], then sel increments.
REQ-014 Bit order: the first accepted bit of a frame lands in dout[0], the eighth in dout[7] (LSB first).
REQ-015 Frame complete on the accept with sel==7 (8 bits, or 9 with parity): dout loads {din,col[6:0]} and dout_valid goes 1 on the next edge; sel wraps to 0.
REQ-016 din_ready = 1 unless a frame-completing accept is pending while dout_valid=1 and dout_ready=0; non-final bits are accepted even while dout is held.
REQ-017 dout_valid clears on dout_ready=1 unless a new frame completes in the same cycle, in which case it stays 1 and dout takes the new byte (no bubble).
REQ-018 dout and parity_err are stable while dout_valid=1 and dout_ready=0.
REQ-019 din_valid=0 cycles do not advance sel; gaps of any length between bits are legal.
REQ-020 flush=1: sel goes to 0 and col is cleared on the next edge; dout, dout_valid and parity_err are unaffected; a bit presented with flush=1 is dropped and din_ready=0 that cycle.
REQ-021 Latency: dout_valid rises exactly one cycle after the frame-completing accept.
REQ-022 States: COLLECT (sel 0..6 or 0..7) and LAST (final slot); the final-slot state is the only one in which din_ready can go 0.

Reset
REQ-023 rst=1 on a rising edge: sel=0, col=0, dout=8'h00, dout_valid=0, parity_err=0; overrides flush and all accepts.
REQ-024 Reset mid-frame discards the partial frame; the first bit accepted after reset lands in dout[0].
REQ-025 din_ready is 1 in the first cycle after reset release.

Configuration
REQ-026 Macro DEMUX_PARITY_CHECK_EN defined: frame is 9 bits, 8 data then one even-parity bit; select counts 0..8 (sel outputs the low 3 bits, saturating display at 7 for the parity slot); completion is the 9th accept; parity_err = XOR of all 9 bits, loaded with dout.
REQ-027 Macro undefined: frame is 8 bits, no parity slot, parity_err tied 0.

Verification
REQ-028 Reset, then bits 1,0,1,1,0,0,1,0 back-to-back, dout_ready=1 -> one cycle later dout=8'h4D, dout_valid=1 for one cycle.
REQ-029 Two frames 8'hA5 then 8'h3C, dout_ready=0 until after second frame's 7th bit -> din_ready=0 on the 8th bit; raise dout_ready -> 8'hA5 consumed, next cycle 8'h3C presented, no bit lost.
REQ-030 Frame completes in the same cycle dout_ready=1 on a held byte -> dout_valid stays 1, dout changes to the new byte, no idle cycle.
REQ-031 Send 3 bits, assert flush, then send 8'hFF -> dout=8'hFF; same with rst instead of flush -> dout=8'hFF, prior dout_valid cleared.
REQ-032 Bits with random din_valid gaps (up to 5 idle cycles) for 8'h81 -> dout=8'h81; sel only advances on accepts.
REQ-033 With DEMUX_PARITY_CHECK_EN: 8'h4D + parity 0 -> parity_err=0; 8'h4D + parity 1 -> parity_err=1; without the macro parity_err stays 0 throughout.
